// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode/state encodings and saturation helpers for alu_seq.
// Saturation helpers are only referenced when ALU_SEQ_SAT_EN is defined.
package alu_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_MUL  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    // Largest signed value representable in 'width' bits, zero-extended to 32 bits
    function automatic logic [31:0] sat_max(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // Most negative signed value in 'width' bits (only the low 'width' bits are meaningful)
    function automatic logic [31:0] sat_min(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// alu_seq_flags: combinational flag generator placed ahead of the result register.
// Produces parity/overflow/compare flags and, when ALU_SEQ_SAT_EN is defined,
// clamps ADD/SUB/MUL results to the signed range on overflow.
module alu_seq_flags
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_y_raw,
    input  logic [WIDTH-1:0] i_prod_hi,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_y,
    output logic             o_parity,
    output logic             o_overflow,
    output logic             o_greater,
    output logic             o_is_eq,
    output logic             o_less
);

    logic w_sign_a;
    logic w_sign_b;
    logic w_sign_y;
    logic w_ovf;

    assign w_sign_a = i_a[WIDTH-1];
    assign w_sign_b = i_b[WIDTH-1];
    assign w_sign_y = i_y_raw[WIDTH-1];

    // Signed overflow of the wrapped result; MUL compares the upper half to the sign extension
    always_comb begin
        w_ovf = 1'b0;
        case (i_op)
            OP_ADD:  w_ovf = (w_sign_a == w_sign_b) && (w_sign_y != w_sign_a);
            OP_SUB:  w_ovf = (w_sign_a != w_sign_b) && (w_sign_y != w_sign_a);
            OP_MUL:  w_ovf = (i_prod_hi != {WIDTH{w_sign_y}});
            default: w_ovf = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_SAT_EN
    localparam logic [31:0] SAT_MAX_32 = sat_max(WIDTH);
    localparam logic [31:0] SAT_MIN_32 = sat_min(WIDTH);

    logic w_sat_neg;

    // Clamp toward the sign of the true result when it does not fit in WIDTH bits
    always_comb begin
        w_sat_neg = (i_op == OP_MUL) ? (w_sign_a ^ w_sign_b) : w_sign_a;
        o_y       = i_y_raw;
        if (w_ovf) begin
            o_y = w_sat_neg ? SAT_MIN_32[WIDTH-1:0] : SAT_MAX_32[WIDTH-1:0];
        end
    end
`else
    assign o_y = i_y_raw;
`endif

    assign o_overflow = w_ovf;
    assign o_parity   = ^o_y;
    assign o_greater  = $signed(i_a) >  $signed(i_b);
    assign o_is_eq    = (i_a == i_b);
    assign o_less     = $signed(i_a) <  $signed(i_b);

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with a registered result stage and an iterative
// shift-add signed multiplier (magnitude multiply with sign correction).
// Optional build macro: ALU_SEQ_SAT_EN (saturating ADD/SUB/MUL).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             parity,
    output logic             overflow,
    output logic             greater,
    output logic             is_eq,
    output logic             less,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             r_state;
    state_e             w_state_next;
    logic               w_rdy_state;
    logic               w_out_valid;
    logic               w_busy;

    op_e                w_op_in;
    logic               w_in_mul;
    logic               w_accept;
    logic               w_start_mul;
    logic               w_load_alu;
    logic               w_mul_done;

    logic [31:0]        w_shamt;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod;

    logic [WIDTH-1:0]   w_f_a;
    logic [WIDTH-1:0]   w_f_b;
    logic [WIDTH-1:0]   w_f_raw;
    logic [WIDTH-1:0]   w_f_hi;
    op_e                w_f_op;
    logic [WIDTH-1:0]   w_f_y;
    logic               w_f_parity;
    logic               w_f_overflow;
    logic               w_f_greater;
    logic               w_f_is_eq;
    logic               w_f_less;

    logic [WIDTH-1:0]   r_y;
    logic               r_parity;
    logic               r_overflow;
    logic               r_greater;
    logic               r_is_eq;
    logic               r_less;

    assign w_op_in     = op_e'(op);
    assign w_in_mul    = (w_op_in == OP_MUL);
    assign w_accept    = in_valid & w_rdy_state;
    assign w_start_mul = w_accept & w_in_mul;
    assign w_load_alu  = w_accept & ~w_in_mul;
    assign w_mul_done  = (r_state == ST_MUL) && (r_cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_rdy_state  = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rdy_state = 1'b1;
                if (in_valid) begin
                    w_state_next = w_in_mul ? ST_MUL : ST_HOLD;
                end
            end
            ST_MUL: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_out_valid = 1'b1;
                w_rdy_state = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_next = w_in_mul ? ST_MUL : ST_HOLD;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Single-cycle operations; MUL and the reserved code yield zero here
    always_comb begin
        w_shamt = 32'(b) % 32'(WIDTH);
        w_alu   = '0;
        case (w_op_in)
            OP_ADD:  w_alu = a + b;
            OP_SUB:  w_alu = a - b;
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_XOR:  w_alu = a ^ b;
            OP_SHL:  w_alu = a << w_shamt;
            default: w_alu = '0;
        endcase
    end

    assign w_a_mag    = a[WIDTH-1] ? -a : a;
    assign w_b_mag    = b[WIDTH-1] ? -b : b;
    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_neg ? -w_acc_step : w_acc_step;

    // Shift-add multiplier: load magnitudes on accept, one multiplier bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else if (w_start_mul) begin
            r_a      <= a;
            r_b      <= b;
            r_mplier <= w_b_mag;
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH);
            r_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (r_state == ST_MUL) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    // The finishing multiply uses the latched operands; otherwise the live beat
    assign w_f_a   = (r_state == ST_MUL) ? r_a : a;
    assign w_f_b   = (r_state == ST_MUL) ? r_b : b;
    assign w_f_op  = (r_state == ST_MUL) ? OP_MUL : w_op_in;
    assign w_f_raw = (r_state == ST_MUL) ? w_prod[WIDTH-1:0] : w_alu;
    assign w_f_hi  = (r_state == ST_MUL) ? w_prod[2*WIDTH-1:WIDTH] : '0;

    alu_seq_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .i_a        (w_f_a),
        .i_b        (w_f_b),
        .i_y_raw    (w_f_raw),
        .i_prod_hi  (w_f_hi),
        .i_op       (w_f_op),
        .o_y        (w_f_y),
        .o_parity   (w_f_parity),
        .o_overflow (w_f_overflow),
        .o_greater  (w_f_greater),
        .o_is_eq    (w_f_is_eq),
        .o_less     (w_f_less)
    );

    // Result stage: captured on a single-cycle accept or on the last multiply step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y        <= '0;
            r_parity   <= 1'b0;
            r_overflow <= 1'b0;
            r_greater  <= 1'b0;
            r_is_eq    <= 1'b0;
            r_less     <= 1'b0;
        end else if (w_load_alu || w_mul_done) begin
            r_y        <= w_f_y;
            r_parity   <= w_f_parity;
            r_overflow <= w_f_overflow;
            r_greater  <= w_f_greater;
            r_is_eq    <= w_f_is_eq;
            r_less     <= w_f_less;
        end
    end

    // in_ready is held low while reset is asserted
    assign in_ready  = w_rdy_state & rst_n;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign y         = r_y;
    assign parity    = r_parity;
    assign overflow  = r_overflow;
    assign greater   = r_greater;
    assign is_eq     = r_is_eq;
    assign less      = r_less;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scenarios plus a randomized stream checked against an
// integer-arithmetic reference model. Honours ALU_SEQ_SAT_EN when defined.
module tb_alu_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] y;
        logic         par;
        logic         ovf;
        logic         gt;
        logic         eq;
        logic         lt;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         parity;
    logic         overflow;
    logic         greater;
    logic         is_eq;
    logic         less;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .parity    (parity),
        .overflow  (overflow),
        .greater   (greater),
        .is_eq     (is_eq),
        .less      (less),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: true signed arithmetic on wide integers, then reduce to W bits
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] mop);
        res_t   r;
        longint sa, sb, full, maxv, minv;
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        sa   = ma[W-1] ? longint'(ma) - (longint'(1) << W) : longint'(ma);
        sb   = mb[W-1] ? longint'(mb) - (longint'(1) << W) : longint'(mb);
        r    = '0;
        full = 0;
        case (mop)
            3'd0: full = sa + sb;
            3'd1: full = sa - sb;
            3'd2: r.y = ma & mb;
            3'd3: r.y = ma | mb;
            3'd4: r.y = ma ^ mb;
            3'd5: r.y = ma << (longint'(mb) % W);
            3'd6: full = sa * sb;
            default: r.y = '0;
        endcase
        if (mop == 3'd0 || mop == 3'd1 || mop == 3'd6) begin
            r.ovf = (full > maxv) || (full < minv);
            r.y   = full[W-1:0];
`ifdef ALU_SEQ_SAT_EN
            if (full > maxv) r.y = maxv[W-1:0];
            else if (full < minv) r.y = minv[W-1:0];
`endif
        end
        r.par = ^r.y;
        r.gt  = sa > sb;
        r.eq  = sa == sb;
        r.lt  = sa < sb;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        #1;
        checks++;
        if ({in_ready, out_valid, y, parity, overflow, greater, is_eq, less, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {in_ready, out_valid, y, parity, overflow, greater, is_eq, less, busy});
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        tick();
        $display("reset: done");
    endtask

    task automatic test_add_overflow();
        res_t obs, exp;
`ifdef ALU_SEQ_SAT_EN
        exp = '{y: 8'h7F, par: 1'b1, ovf: 1'b1, gt: 1'b1, eq: 1'b0, lt: 1'b0};
`else
        exp = '{y: 8'h80, par: 1'b1, ovf: 1'b1, gt: 1'b1, eq: 1'b0, lt: 1'b0};
`endif
        in_valid = 1'b1; a = 8'h7F; b = 8'h01; op = 3'd0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        obs = {y, parity, overflow, greater, is_eq, less};
        checks++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errors++;
            $display("FAIL add_ovf: valid=%b got %h want %h", out_valid, obs, exp);
        end
        $display("add 7f+01: y=%h ovf=%b", y, overflow);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_sub_equal();
        res_t obs, exp;
        exp = '{y: 8'h00, par: 1'b0, ovf: 1'b0, gt: 1'b0, eq: 1'b1, lt: 1'b0};
        in_valid = 1'b1; a = 8'h05; b = 8'h05; op = 3'd1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        obs = {y, parity, overflow, greater, is_eq, less};
        checks++;
        if (out_valid !== 1'b1 || obs !== exp) begin
            errors++;
            $display("FAIL sub_eq: valid=%b got %h want %h", out_valid, obs, exp);
        end
        $display("sub 05-05: y=%h eq=%b", y, is_eq);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_mul();
        res_t obs, exp;
        exp = '{y: 8'hF4, par: 1'b1, ovf: 1'b0, gt: 1'b0, eq: 1'b0, lt: 1'b1};
        in_valid = 1'b1; a = 8'hFD; b = 8'h04; op = 3'd6; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= W; c++) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy: cycle %0d busy=%b in_ready=%b out_valid=%b want 1/0/0",
                         c, busy, in_ready, out_valid);
            end
            tick();
        end
        obs = {y, parity, overflow, greater, is_eq, less};
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || obs !== exp) begin
            errors++;
            $display("FAIL mul_result: valid=%b busy=%b got %h want %h", out_valid, busy, obs, exp);
        end
        $display("mul fd*04: y=%h less=%b", y, less);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ea = W'($urandom); eb = W'($urandom);
            in_valid = 1'b1; a = ea; b = eb; op = 3'd2;
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || y !== (ea & eb)) begin
                errors++;
                $display("FAIL b2b_beat%0d: valid=%b rdy=%b got %h want %h",
                         i, out_valid, in_ready, y, ea & eb);
            end
            $display("b2b and %h&%h: y=%h", ea, eb, y);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_hold_stall();
        res_t obs, exp;
        exp = '{y: 8'h55, par: 1'b0, ovf: 1'b0, gt: 1'b1, eq: 1'b0, lt: 1'b0};
        in_valid = 1'b1; a = 8'h5A; b = 8'h0F; op = 3'd4; out_ready = 1'b0;
        tick();
        a = 8'h11; b = 8'h22; op = 3'd0;
        for (int c = 0; c < 5; c++) begin
            obs = {y, parity, overflow, greater, is_eq, less};
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== exp) begin
                errors++;
                $display("FAIL stall%0d: valid=%b rdy=%b got %h want %h",
                         c, out_valid, in_ready, obs, exp);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("stall xor 5a^0f: drained");
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: out_valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_dup: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        in_valid = 1'b1; a = 8'h93; b = 8'h7B; op = 3'd6; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, y, parity, overflow, greater, is_eq, less, busy} !== '0) begin
            errors++;
            $display("FAIL rst_mul_outputs: got %h want 0",
                     {in_ready, out_valid, y, parity, overflow, greater, is_eq, less, busy});
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mul_release: rdy=%b valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
        seen = 0;
        for (int c = 0; c < 2 * W; c++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mul_stale: %0d result cycles want 0", seen);
        end
        $display("reset mid-mul: aborted");
    endtask

    task automatic test_random();
        res_t exp_q[$];
        res_t obs, e;
        logic exp_rdy;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = W'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            op        = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            exp_rdy = out_valid ? out_ready : ~busy;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_ready: cycle %0d got %b want %b", cyc, in_ready, exp_rdy);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if ($countones({greater, is_eq, less}) != 1) begin
                    errors++;
                    $display("FAIL rnd_onehot: cycle %0d got %b%b%b want one-hot", cyc, greater, is_eq, less);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                obs = {y, parity, overflow, greater, is_eq, less};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious: cycle %0d got %h want none", cyc, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL rnd_result: cycle %0d got %h want %h", cyc, obs, e);
                    end
                    $display("rnd drain: y=%h flags=%b", obs.y, obs[4:0]);
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(model(a, b, op));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4 * W && exp_q.size() > 0; k++) begin
            #4;
            if (out_valid === 1'b1) begin
                obs = {y, parity, overflow, greater, is_eq, less};
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL rnd_tail: got %h want %h", obs, e);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_lost: %0d beats undelivered want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_equal();
        test_mul();
        test_back_to_back();
        test_hold_stall();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
